// File: rtl/enc_sched_pkg.sv
// enc_sched_pkg
//   Shared constants and types for the packet scheduler that feeds enc8to10.
//   K281_9B / K285_9B are the {Kbit, byte} control codes on the encoder input.
//   DEF_PREAMBLE_CNT / DEF_TRAIL_CYC must agree with the enc8to10 build in use.
package enc_sched_pkg;

   localparam logic [8:0] K281_9B          = 9'h13C;
   localparam logic [8:0] K285_9B          = 9'h1BC;
   localparam logic [7:0] HAZARD_BYTE      = 8'hBC;
   localparam int         DEF_PREAMBLE_CNT = 4;
   localparam int         DEF_TRAIL_CYC    = 5;

   typedef enum logic [2:0] {
      IDLE,
      PRE,
      DATA,
      EOP,
      TRAIL
   } sched_state_t;

   // The encoder reads this data byte as end-of-data, so the scheduler flags it.
   function automatic logic is_hazard(input logic [7:0] b);
      return (b == HAZARD_BYTE);
   endfunction

endpackage

// File: rtl/enc_pkt_sched_rr_arbiter.sv
// rr_arbiter
//   Combinational round-robin pick: the first set bit of req searching upward
//   from ptr+1 and wrapping back to ptr itself.
//   Ports:
//     req  [N-1:0]     request vector
//     ptr  [IDX_W-1:0] index of the previous winner
//     gnt  [N-1:0]     one-hot winner (all zero when no request)
//     idx  [IDX_W-1:0] encoded winner index
//     any              at least one request present
module rr_arbiter #(
   parameter int N     = 2,
   parameter int IDX_W = $clog2(N)
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   output logic [N-1:0]     gnt,
   output logic [IDX_W-1:0] idx,
   output logic             any
);

   // One spare bit so ptr+k (at most 2N-1) can be folded back below N.
   logic [IDX_W:0] cand;

   always_comb begin
      gnt  = '0;
      idx  = '0;
      any  = 1'b0;
      cand = '0;
      for (int k = 1; k <= N; k++) begin
         cand = {1'b0, ptr} + (IDX_W+1)'(k);
         if (cand >= (IDX_W+1)'(N)) begin
            cand = cand - (IDX_W+1)'(N);
         end
         if (!any && req[cand[IDX_W-1:0]]) begin
            any                   = 1'b1;
            gnt[cand[IDX_W-1:0]]  = 1'b1;
            idx                   = cand[IDX_W-1:0];
         end
      end
   end

endmodule

// File: rtl/enc_pkt_sched.sv
// enc_pkt_sched
//   Shares one enc8to10 encoder between NUM_REQ byte-stream requesters. A
//   round-robin winner owns the encoder for a whole frame: PREAMBLE_CNT K28.1,
//   its payload bytes, one K28.5, then TRAIL_CYC silent cycles while the encoder
//   appends CRC and its own K28.5.
//   Ports:
//     clk, reset            clock; asynchronous active-high reset
//     req       [N-1:0]     per-requester packet-ready
//     req_len   [N*LEN_W]   payload length per requester, sampled at grant
//     src_valid [N-1:0]     payload byte available
//     src_data  [N*8]       payload bytes
//     src_pop   [N-1:0]     combinational byte-consume strobe (owner only)
//     grant     [N-1:0]     registered one-hot frame owner
//     pushin, datain[8:0], startin   registered encoder drive
//     busy                  high from grant through the last trail cycle
//     pkt_done              pulse on the last trail cycle
//     data_hazard           pulse with a pushed payload byte of 8'hBC
module enc_pkt_sched
   import enc_sched_pkg::*;
#(
   parameter int NUM_REQ      = 2,
   parameter int LEN_W        = 8,
   parameter int PREAMBLE_CNT = DEF_PREAMBLE_CNT,
   parameter int TRAIL_CYC    = DEF_TRAIL_CYC
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUM_REQ-1:0]       req,
   input  logic [NUM_REQ*LEN_W-1:0] req_len,
   input  logic [NUM_REQ-1:0]       src_valid,
   input  logic [NUM_REQ*8-1:0]     src_data,
   output logic [NUM_REQ-1:0]       src_pop,
   output logic [NUM_REQ-1:0]       grant,
   output logic                     pushin,
   output logic [8:0]               datain,
   output logic                     startin,
   output logic                     busy,
   output logic                     pkt_done,
   output logic                     data_hazard
);

   localparam int IDX_W   = $clog2(NUM_REQ);
   localparam int PRE_W   = (PREAMBLE_CNT > 1) ? $clog2(PREAMBLE_CNT) : 1;
   // Trail counter runs 0..TRAIL_CYC: pkt_done fires at TRAIL_CYC-1 and the
   // extra count holds the final silent cycle before returning to IDLE.
   localparam int TRAIL_W = $clog2(TRAIL_CYC + 1);

   logic [LEN_W-1:0] len_arr  [NUM_REQ];
   logic [7:0]       byte_arr [NUM_REQ];

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
         assign len_arr[gi]  = req_len[gi*LEN_W +: LEN_W];
         assign byte_arr[gi] = src_data[gi*8 +: 8];
      end
   endgenerate

   sched_state_t        state_reg;
   logic [NUM_REQ-1:0]  grant_reg;
   logic [IDX_W-1:0]    gidx_reg;
   logic [IDX_W-1:0]    ptr_reg;
   logic [LEN_W-1:0]    rem_reg;
   logic [PRE_W-1:0]    pre_cnt_reg;
   logic [TRAIL_W-1:0]  trail_cnt_reg;
   logic                pushin_reg;
   logic [8:0]          datain_reg;
   logic                startin_reg;
   logic                busy_reg;
   logic                done_reg;
   logic                hazard_reg;

   logic [NUM_REQ-1:0]  arb_gnt;
   logic [IDX_W-1:0]    arb_idx;
   logic                arb_any;
   logic                pop_now;
   logic [7:0]          sel_byte;

   rr_arbiter #(
      .N     (NUM_REQ),
      .IDX_W (IDX_W)
   ) u_arb (
      .req (req),
      .ptr (ptr_reg),
      .gnt (arb_gnt),
      .idx (arb_idx),
      .any (arb_any)
   );

   assign sel_byte = byte_arr[gidx_reg];
   assign pop_now  = (state_reg == DATA) && (rem_reg != '0) && src_valid[gidx_reg];
   assign src_pop  = pop_now ? grant_reg : '0;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg     <= IDLE;
         grant_reg     <= '0;
         gidx_reg      <= '0;
         ptr_reg       <= IDX_W'(NUM_REQ - 1);
         rem_reg       <= '0;
         pre_cnt_reg   <= '0;
         trail_cnt_reg <= '0;
         pushin_reg    <= 1'b0;
         datain_reg    <= '0;
         startin_reg   <= 1'b0;
         busy_reg      <= 1'b0;
         done_reg      <= 1'b0;
         hazard_reg    <= 1'b0;
      end else begin
         // Encoder drive and pulses are single-cycle unless a state re-asserts them.
         pushin_reg  <= 1'b0;
         datain_reg  <= '0;
         startin_reg <= 1'b0;
         done_reg    <= 1'b0;
         hazard_reg  <= 1'b0;

         case (state_reg)
            IDLE: begin
               if (arb_any) begin
                  grant_reg   <= arb_gnt;
                  gidx_reg    <= arb_idx;
                  ptr_reg     <= arb_idx;
                  rem_reg     <= len_arr[arb_idx];
                  pre_cnt_reg <= '0;
                  busy_reg    <= 1'b1;
                  state_reg   <= PRE;
               end
            end

            PRE: begin
               pushin_reg  <= 1'b1;
               datain_reg  <= K281_9B;
               startin_reg <= (pre_cnt_reg == '0);
               pre_cnt_reg <= pre_cnt_reg + PRE_W'(1);
               if (pre_cnt_reg == PRE_W'(PREAMBLE_CNT - 1)) begin
                  state_reg <= (rem_reg == '0) ? EOP : DATA;
               end
            end

            DATA: begin
               // No pop means a bubble; the encoder's data state tolerates gaps.
               if (pop_now) begin
                  pushin_reg <= 1'b1;
                  datain_reg <= {1'b0, sel_byte};
                  hazard_reg <= is_hazard(sel_byte);
                  rem_reg    <= rem_reg - LEN_W'(1);
                  if (rem_reg == LEN_W'(1)) begin
                     state_reg <= EOP;
                  end
               end
            end

            EOP: begin
               pushin_reg    <= 1'b1;
               datain_reg    <= K285_9B;
               trail_cnt_reg <= '0;
               state_reg     <= TRAIL;
            end

            TRAIL: begin
               trail_cnt_reg <= trail_cnt_reg + TRAIL_W'(1);
               if (trail_cnt_reg == TRAIL_W'(TRAIL_CYC - 1)) begin
                  done_reg <= 1'b1;
               end
               if (trail_cnt_reg == TRAIL_W'(TRAIL_CYC)) begin
                  grant_reg <= '0;
                  busy_reg  <= 1'b0;
                  state_reg <= IDLE;
               end
            end

            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

   assign grant       = grant_reg;
   assign pushin      = pushin_reg;
   assign datain      = datain_reg;
   assign startin     = startin_reg;
   assign busy        = busy_reg;
   assign pkt_done    = done_reg;
   assign data_hazard = hazard_reg;

endmodule

// File: tb/tb_enc_pkt_sched.sv
// tb_enc_pkt_sched
//   Scoreboard bench for enc_pkt_sched: each planned frame pushes its expected
//   encoder words and frame facts into queues; a negedge monitor pops and
//   compares as the scheduler produces them.
module tb_enc_pkt_sched;

   localparam int NR  = 2;
   localparam int LW  = 8;
   localparam int PRE = 4;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic [NR-1:0]     req = '0;
   logic [NR*LW-1:0]  req_len = '0;
   logic [NR-1:0]     src_valid = '0;
   logic [NR*8-1:0]   src_data = '0;
   logic [NR-1:0]     src_pop;
   logic [NR-1:0]     grant;
   logic              pushin;
   logic [8:0]        datain;
   logic              startin;
   logic              busy;
   logic              pkt_done;
   logic              data_hazard;

   always #5 clk = ~clk;

   enc_pkt_sched #(
      .NUM_REQ (NR),
      .LEN_W   (LW)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .req         (req),
      .req_len     (req_len),
      .src_valid   (src_valid),
      .src_data    (src_data),
      .src_pop     (src_pop),
      .grant       (grant),
      .pushin      (pushin),
      .datain      (datain),
      .startin     (startin),
      .busy        (busy),
      .pkt_done    (pkt_done),
      .data_hazard (data_hazard)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Source model: per-requester byte memories with read/write pointers.
   logic [7:0]    src_mem [NR][512];
   int            src_wr [NR];
   int            src_rd [NR];
   int            plan_rd [NR];
   int            stall_left [NR];
   int            stall_amt [NR];
   bit            stall_arm [NR];
   logic [NR-1:0] pop_mask = '0;

   typedef struct {
      logic [NR-1:0] gnt;
      int            len;
      int            bub;
   } frame_t;

   frame_t      frm_q [$];
   logic [10:0] exp_q [$];

   // Monitor state
   logic [NR-1:0] prev_grant = '0;
   bit            in_frame = 0;
   bit            started = 0;
   bit            have_done = 0;
   bit            b2b = 0;
   int            cyc = 0;
   int            bub = 0;
   int            exp_bub = 0;
   int            exp_len = 0;
   int            since_done = 0;
   int            frames_started = 0;
   frame_t        mon_f;
   logic [10:0]   mon_e;

   task automatic load(input int r, input logic [7:0] b);
      src_mem[r][src_wr[r]] = b;
      src_wr[r]++;
   endtask

   task automatic drive_src();
      for (int r = 0; r < NR; r++) begin
         src_valid[r]       = (src_rd[r] < src_wr[r]) && (stall_left[r] == 0);
         src_data[r*8 +: 8] = src_mem[r][src_rd[r]];
      end
   endtask

   // Plan one frame for requester r: expected words {hazard, startin, datain}.
   task automatic plan_frame(input int r, input int len, input int stall);
      frame_t     f;
      logic [7:0] b;
      f.gnt = NR'(1) << r;
      f.len = len;
      f.bub = stall;
      frm_q.push_back(f);
      for (int i = 0; i < PRE; i++) begin
         exp_q.push_back({1'b0, (i == 0), 9'h13C});
      end
      for (int i = 0; i < len; i++) begin
         b = src_mem[r][plan_rd[r]];
         plan_rd[r]++;
         exp_q.push_back({(b == 8'hBC), 1'b0, 1'b0, b});
      end
      exp_q.push_back({2'b00, 9'h1BC});
      if (stall > 0) begin
         stall_arm[r] = 1'b1;
         stall_amt[r] = stall;
      end
      req_len[r*LW +: LW] = LW'(len);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      for (int r = 0; r < NR; r++) begin
         if (pop_mask[r]) begin
            src_rd[r]++;
            if (stall_arm[r]) begin
               stall_left[r] = stall_amt[r];
               stall_arm[r]  = 1'b0;
            end
         end
      end
      pop_mask = '0;
      drive_src();
      for (int r = 0; r < NR; r++) begin
         if (stall_left[r] > 0) stall_left[r]--;
      end
   endtask

   task automatic check_quiet_outs(input string tag);
      check_val(tag, 32'({src_pop, grant, pushin, datain, startin, busy, pkt_done, data_hazard}), 32'd0);
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      req   = '0;
      exp_q.delete();
      frm_q.delete();
      for (int r = 0; r < NR; r++) begin
         src_wr[r]     = 0;
         src_rd[r]     = 0;
         plan_rd[r]    = 0;
         stall_left[r] = 0;
         stall_arm[r]  = 1'b0;
      end
      pop_mask  = '0;
      have_done = 0;
      b2b       = 0;
      drive_src();
      @(posedge clk);
      @(posedge clk);
      #1;
      check_quiet_outs("reset_outs");
      reset = 1'b0;
   endtask

   task automatic wait_grant();
      int n;
      n = 0;
      while (grant == '0 && n < 40) begin
         step();
         n++;
      end
      if (grant == '0) check_val("grant_wait", 32'(grant), 32'd1);
   endtask

   task automatic wait_idle(input int maxc);
      int n;
      n = 0;
      while ((busy || in_frame || exp_q.size() != 0) && n < maxc) begin
         step();
         n++;
      end
      if (busy || in_frame) check_val("idle_wait", 32'(busy), 32'd0);
      step();
      step();
   endtask

   // Monitor / scoreboard
   always @(negedge clk) begin
      if (reset) begin
         prev_grant = '0;
         in_frame   = 0;
         pop_mask   = '0;
      end else begin
         pop_mask = src_pop;
         if (have_done) since_done++;
         if (in_frame) cyc++;
         if (grant != '0 && prev_grant == '0) begin
            frames_started++;
            if (frm_q.size() == 0) begin
               check_val("grant_unexpected", 32'(grant), 32'd0);
            end else begin
               mon_f = frm_q.pop_front();
               check_val("grant", 32'(grant), 32'(mon_f.gnt));
               exp_bub = mon_f.bub;
               exp_len = mon_f.len;
            end
            if (b2b && have_done) check_val("frame_gap", since_done, 2);
            have_done = 0;
            in_frame  = 1;
            started   = 0;
            cyc       = 0;
            bub       = 0;
         end
         if (pushin) begin
            if (in_frame && !started) check_val("first_push_lat", cyc, 1);
            started = 1;
            if (exp_q.size() == 0) begin
               check_val("push_unexpected", 32'(pushin), 32'd0);
            end else begin
               mon_e = exp_q.pop_front();
               check_val("push_word", 32'({data_hazard, startin, datain}), 32'(mon_e));
            end
            if (datain == 9'h1BC && in_frame) check_val("bubbles", bub, exp_bub);
         end else begin
            check_val("quiet_word", 32'({data_hazard, startin, datain}), 32'd0);
            if (in_frame && started) bub++;
         end
         if (pkt_done) begin
            check_val("done_lat", cyc, 10 + exp_len + exp_bub);
            check_val("busy_at_done", 32'(busy), 32'd1);
            $display("frame grant=%b len=%0d bubbles=%0d done_after=%0d cycles", grant, exp_len, bub, cyc);
            in_frame   = 0;
            have_done  = 1;
            since_done = 0;
         end
         prev_grant = grant;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      logic [7:0] rb;

      #2;
      apply_reset();

      // Single frame, requester 0, three bytes
      load(0, 8'h11); load(0, 8'h22); load(0, 8'h33);
      plan_frame(0, 3, 0);
      req = 2'b01;
      wait_grant();
      req = 2'b00;
      wait_idle(60);

      // Round robin with both requests held
      apply_reset();
      load(0, 8'hA0); load(0, 8'hA1);
      load(1, 8'hB0); load(1, 8'hB1);
      plan_frame(0, 1, 0);
      plan_frame(1, 1, 0);
      plan_frame(0, 1, 0);
      plan_frame(1, 1, 0);
      b2b = 1;
      n = frames_started;
      req = 2'b11;
      begin
         int k;
         k = 0;
         while (frames_started < n + 4 && k < 200) begin
            step();
            k++;
         end
      end
      req = 2'b00;
      check_val("rr_frames", frames_started - n, 4);
      wait_idle(60);
      b2b = 0;

      // Stall: 3 bubble cycles between two payload bytes, third byte left unread
      load(1, 8'h55); load(1, 8'h66); load(1, 8'h77);
      plan_frame(1, 2, 3);
      req = 2'b10;
      wait_grant();
      req = 2'b00;
      wait_idle(60);
      check_val("no_extra_pop", src_wr[1] - src_rd[1], 1);
      src_rd[1]  = src_wr[1];
      plan_rd[1] = src_wr[1];
      drive_src();

      // Zero-length frame
      plan_frame(0, 0, 0);
      req = 2'b01;
      wait_grant();
      req = 2'b00;
      wait_idle(60);

      // Hazard byte in the payload
      load(1, 8'h12); load(1, 8'hBC); load(1, 8'h34);
      plan_frame(1, 3, 0);
      req = 2'b10;
      wait_grant();
      req = 2'b00;
      wait_idle(60);

      // Maximum length (2^LEN_W - 1)
      for (int i = 0; i < 255; i++) begin
         rb = 8'($urandom);
         if (i == 100) rb = 8'hBC;
         load(0, rb);
      end
      plan_frame(0, 255, 0);
      req = 2'b01;
      wait_grant();
      req = 2'b00;
      wait_idle(400);

      // Reset during the second payload byte
      load(0, 8'h01); load(0, 8'h02); load(0, 8'h03); load(0, 8'h04);
      plan_frame(0, 4, 0);
      req = 2'b01;
      wait_grant();
      req = 2'b00;
      n = 0;
      while (!(pushin && datain == 9'h002) && n < 30) begin
         step();
         n++;
      end
      check_val("second_byte_seen", 32'(datain), 32'h002);
      #2;
      reset = 1'b1;
      #1;
      check_quiet_outs("async_reset_outs");
      apply_reset();
      load(0, 8'hC0);
      load(1, 8'hD0);
      plan_frame(0, 1, 0);
      req_len[LW +: LW] = LW'(1);
      req = 2'b11;
      wait_grant();
      req = 2'b00;
      wait_idle(60);

      check_val("sb_drained", exp_q.size(), 0);
      check_val("frames_drained", frm_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/enc_pkt_sched.md
Name: enc_pkt_sched

Overview:
- Packet scheduler that shares one enc8to10 encoder between NUM_REQ byte-stream requesters.
- Arbitrates round-robin between requesters and drives the encoder's pushin/datain/startin with the full frame: preamble of PREAMBLE_CNT K28.1, payload bytes, K28.5 terminator.
- After the terminator it stays silent for the encoder's CRC/K28.5 trailer window.
- Sits directly upstream of enc8to10 in the serial link transmit path.

Parameters:
- NUM_REQ, 2, number of requesters (2..8)
- LEN_W, 8, width of the per-packet payload length field
- PREAMBLE_CNT, 4, number of K28.1 codes per frame; must match the encoder's K28.1 count
- TRAIL_CYC, 5, idle cycles after K28.5 while the encoder emits 4 CRC bytes plus K28.5

Ports:
- clk, input, 1, system clock
- reset, input, 1, reset; one clock, asynchronous and active-high
- req, input, NUM_REQ, per-requester packet-ready request
- req_len, input, NUM_REQ*LEN_W, payload byte count per requester; slice i belongs to requester i; sampled at grant
- src_valid, input, NUM_REQ, payload byte available from requester i
- src_data, input, NUM_REQ*8, payload byte from requester i
- src_pop, output, NUM_REQ, one-hot byte-consume strobe (combinational)
- grant, output, NUM_REQ, one-hot owner of the encoder for the current frame (registered)
- pushin, output, 1, encoder push (registered)
- datain, output, 9, encoder input {Kbit, byte} (registered)
- startin, output, 1, encoder start-of-sequence (registered)
- busy, output, 1, high from GRANT through the end of TRAIL
- pkt_done, output, 1, one-cycle pulse on the last TRAIL cycle
- data_hazard, output, 1, one-cycle pulse, aligned with pushin, when a payload byte equals 8'hBC

Behaviour:
- Reset values: all outputs 0; state IDLE; round-robin pointer = NUM_REQ-1, so requester 0 wins first.
- Reset mid-frame aborts the frame immediately; there is no recovery sequence.
- States: IDLE, PRE, DATA, EOP, TRAIL.
- IDLE:
  - If any req bit is high, pick the first set bit searching from pointer+1 (wrapping).
  - Register grant, latch that requester's req_len into rem_cnt, update pointer, then go to PRE.
  - Latency: req high at edge t gives the first K28.1 on pushin at edge t+1.
- PRE:
  - Emit PREAMBLE_CNT consecutive cycles with pushin=1 and datain=9'h13C.
  - startin=1 on the first of these cycles only.
  - Preamble is never stalled.
  - Next state is DATA, or EOP if rem_cnt==0.
- DATA:
  - src_pop[g] = src_valid[g] while rem_cnt != 0.
  - On a pop: the next cycle has pushin=1 and datain={1'b0, src_data[g]}, and rem_cnt decrements.
  - If src_valid[g] is low: pushin=0 next cycle (a bubble). The encoder tolerates bubbles in its data state.
  - When the last byte is popped, go to EOP.
- Hazard byte:
  - A payload byte of 8'hBC is still sent unchanged.
  - data_hazard pulses with it, because the encoder treats that value as end-of-data.
- EOP: one cycle with pushin=1 and datain=9'h1BC, then go to TRAIL.
- TRAIL:
  - pushin=0 for TRAIL_CYC cycles; the encoder outputs CRC and K28.5 during this window.
  - pkt_done pulses on the final cycle.
  - grant clears on entering IDLE.
- Other requesters:
  - req of non-granted requesters is ignored until IDLE.
  - A req that deasserts mid-frame does not abort the frame.
  - The owner may reassert req and competes fairly in the next arbitration.
- Width rules:
  - rem_cnt is LEN_W bits; a length of 2^LEN_W-1 is legal.
  - The PRE and TRAIL counters are clog2-sized and saturate-free because they reload on entry.
- Outputs outside PRE, DATA pushes and EOP: pushin=0, datain=0, startin=0.
- Simultaneous events: a req arriving in the same cycle pkt_done pulses is arbitrated in the following IDLE cycle. This gives a minimum inter-frame gap of 1 cycle after TRAIL.

Decomposition:
- Package enc_sched_pkg holds:
  - K281_9B = 9'h13C and K285_9B = 9'h1BC
  - the state enum {IDLE, PRE, DATA, EOP, TRAIL}
  - a default PREAMBLE_CNT and TRAIL_CYC, shared with enc8to10 users
- One sub-module, rr_arbiter:
  - inputs: req vector and pointer
  - outputs: one-hot gnt and encoded index
  - purely combinational, instantiated once

Test Plan:
- Single frame: reset, then req=2'b01 with req_len[0]=3 and bytes 0x11,0x22,0x33 always valid.
  - Expect 4×9'h13C (startin on the first), then 9'h011, 9'h022, 9'h033, then 9'h1BC.
  - Then 5 idle cycles and pkt_done; total 13 cycles from grant.
- Round robin: req=2'b11 held continuously with len 1 each.
  - Expect grant sequence 01,10,01,10.
  - Each frame is separated by TRAIL plus a 1-cycle IDLE gap.
- Stall: len=2 with src_valid low for 3 cycles between the two bytes.
  - Expect exactly 3 bubble cycles with pushin=0 between the data pushes.
  - No extra pops.
- Zero length: req_len=0.
  - Expect 4×K28.1 immediately followed by 9'h1BC, then TRAIL.
- Hazard: a payload byte of 0xBC.
  - Expect datain=9'h0BC with data_hazard=1 in the same cycle.
- Reset mid-DATA: assert reset during the second payload byte.
  - Expect all outputs 0 asynchronously and state IDLE.
  - The next req from requester 1 is won by requester 0 if both request.
